// File: rtl/step_sequencer.sv
// step_sequencer
//   Merges three step sources (rotary edge, debounced pushbutton, idle
//   auto-advance timer) into one registered single-cycle step pulse for the
//   dispatch FSM. Fixed priority rot > pb > tmr. A hold-off gap follows each
//   step. The dispatch selector is latched alongside every pulse.
//
// Ports
//   clk            in  1  rising-edge clock
//   rst_n          in  1  synchronous active-low reset
//   rotation_event in  1  raw encoder rotation level (async)
//   pb             in  1  raw pushbutton level (async, bouncing)
//   auto_en        in  1  enables the idle auto-advance timer
//   in             in  2  dispatch selector
//   step           out 1  one-cycle advance pulse
//   sel            out 2  `in` captured with the last step
//   src            out 2  source of last step (00 none, 01 rot, 10 pb, 11 tmr)
//   step_cnt       out 8  issued step count, wraps
//   pending        out 3  sticky requests {tmr, pb, rot}

// Two-flop synchronizer with a selectable reset level.
module step_seq_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

module step_sequencer #(
  parameter int TIMEOUT  = 100000000,
  parameter int DEBOUNCE = 1000000,
  parameter int HOLDOFF  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rotation_event,
  input  logic       pb,
  input  logic       auto_en,
  input  logic [1:0] in,
  output logic       step,
  output logic [1:0] sel,
  output logic [1:0] src,
  output logic [7:0] step_cnt,
  output logic [2:0] pending
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = $clog2(HOLDOFF + 1);

  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_HOLD  = 2'b10
  } state_t;

  // ---------------------------------------------------------------
  // Rotation: synchronize, then edge-detect against a history flop.
  // Everything resets to 1 so a level already high at release is not
  // mistaken for a fresh edge.
  // ---------------------------------------------------------------
  logic w_rot_sync;
  logic r_rot_h;
  logic w_rot_rise;

  step_seq_sync #(.RST_VAL(1'b1)) u_rot_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rotation_event),
    .o_q   (w_rot_sync)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_rot_h <= 1'b1;
    else        r_rot_h <= w_rot_sync;
  end

  assign w_rot_rise = w_rot_sync & ~r_rot_h;

  // ---------------------------------------------------------------
  // Pushbutton: synchronize, then require DEBOUNCE consecutive cycles of
  // disagreement with the debounced level before accepting the change.
  // ---------------------------------------------------------------
  logic          w_pb_sync;
  logic          r_pb_db;
  logic [DW-1:0] r_db_cnt;
  logic          w_pb_diff;
  logic          w_pb_flip;
  logic          w_pb_rise;

  step_seq_sync #(.RST_VAL(1'b1)) u_pb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pb),
    .o_q   (w_pb_sync)
  );

  assign w_pb_diff = w_pb_sync ^ r_pb_db;
  assign w_pb_flip = w_pb_diff && (r_db_cnt == DB_LAST);
  // The request is raised on the flip edge itself, not a cycle later.
  assign w_pb_rise = w_pb_flip & w_pb_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pb_db  <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      if (w_pb_flip) r_pb_db <= w_pb_sync;
      if (!w_pb_diff || w_pb_flip) r_db_cnt <= '0;
      else                         r_db_cnt <= r_db_cnt + DW'(1);
    end
  end

  // ---------------------------------------------------------------
  // FSM: grant decision is made in IDLE so the pulse is registered on the
  // same edge the grant is taken; ISSUE is the one cycle step is high.
  // ---------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_pend;
  logic          w_issue;
  logic [2:0]    w_grant;
  logic [1:0]    w_grant_code;

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_grant      = 3'b000;
    w_grant_code = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_issue     = 1'b1;
          w_state_nxt = S_ISSUE;
          if (r_pend[0]) begin
            w_grant      = 3'b001;
            w_grant_code = 2'b01;
          end else if (r_pend[1]) begin
            w_grant      = 3'b010;
            w_grant_code = 2'b10;
          end else begin
            w_grant      = 3'b100;
            w_grant_code = 2'b11;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        // Leave on the edge that takes the count to zero; this yields a
        // step-to-step spacing of HOLDOFF+2.
        if ((r_hold == HW'(1)) || (r_hold == '0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue)                r_hold <= HOLD_LD;
      else if (r_state == S_HOLD) r_hold <= r_hold - HW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Idle timer: counts only while enabled and restarts on every step.
  // ---------------------------------------------------------------
  logic [TW-1:0] r_tmr;
  logic          w_tmr_hit;

  assign w_tmr_hit = auto_en && (r_tmr == TMR_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)                             r_tmr <= '0;
    else if (!auto_en || w_issue || w_tmr_hit) r_tmr <= '0;
    else                                    r_tmr <= r_tmr + TW'(1);
  end

  // ---------------------------------------------------------------
  // Sticky requests. Clearing before OR-ing in the new events makes a
  // same-cycle set win over the grant clear.
  // ---------------------------------------------------------------
  logic [2:0] w_set;

  assign w_set = {w_tmr_hit, w_pb_rise, w_rot_rise};

  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= 3'b000;
    else        r_pend <= (r_pend & ~w_grant) | w_set;
  end

  // ---------------------------------------------------------------
  // Step outputs.
  // ---------------------------------------------------------------
  logic       r_step;
  logic [1:0] r_sel;
  logic [1:0] r_src;
  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step <= 1'b0;
      r_sel  <= 2'b00;
      r_src  <= 2'b00;
      r_cnt  <= 8'd0;
    end else begin
      r_step <= w_issue;
      if (w_issue) begin
        r_sel <= in;
        r_src <= w_grant_code;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign step     = r_step;
  assign sel      = r_sel;
  assign src      = r_src;
  assign step_cnt = r_cnt;
  assign pending  = r_pend;
endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: behavioural reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_step_sequencer;
  localparam int TO   = 20;
  localparam int DEB  = 4;
  localparam int HOLD = 4;
  localparam int MAXE = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rotation_event;
  logic       pb;
  logic       auto_en;
  logic [1:0] in_sel;
  logic       step;
  logic [1:0] sel;
  logic [1:0] src;
  logic [7:0] step_cnt;
  logic [2:0] pending;

  step_sequencer #(.TIMEOUT(TO), .DEBOUNCE(DEB), .HOLDOFF(HOLD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rotation_event (rotation_event),
    .pb             (pb),
    .auto_en        (auto_en),
    .in             (in_sel),
    .step           (step),
    .sel            (sel),
    .src            (src),
    .step_cnt       (step_cnt),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int gcyc     = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, gcyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs sampled since the last reset edge are kept by edge index; anything
  // at or before the reset edge reads as 1 (synchronizers reset high).
  bit         rs [MAXE];
  bit         ps [MAXE];
  int         j = 0;
  bit         m_valid = 0;
  bit         m_db;
  bit   [2:0] m_pend;
  int         m_last;
  int         m_tref;
  bit         m_step;
  bit   [1:0] m_sel;
  bit   [1:0] m_src;
  bit   [7:0] m_cnt;
  bit   [2:0] ev;
  bit   [2:0] gr;
  bit         flip;

  function automatic bit rotv(input int i);
    return (i <= 0 || i >= MAXE) ? 1'b1 : rs[i];
  endfunction
  function automatic bit pbv(input int i);
    return (i <= 0 || i >= MAXE) ? 1'b1 : ps[i];
  endfunction

  always @(posedge clk) begin
    gcyc++;
    if (!rst_n) begin
      j = 0; m_db = 1; m_pend = 0; m_last = -1000; m_tref = 0;
      m_step = 0; m_sel = 0; m_src = 0; m_cnt = 0;
    end else begin
      j++;
      if (j < MAXE) begin
        rs[j] = rotation_event;
        ps[j] = pb;
      end
      ev = 3'b000;
      // rotation level seen two edges late; request on a 0->1 of that view
      if (rotv(j - 2) && !rotv(j - 3)) ev[0] = 1'b1;
      // debounced level changes once the synced view has disagreed with it
      // for DEB consecutive edges
      flip = 1'b1;
      for (int i = j - 1 - DEB; i <= j - 2; i++)
        if (pbv(i) == m_db) flip = 1'b0;
      if (flip) begin
        m_db = !m_db;
        if (m_db) ev[1] = 1'b1;
      end
      // TO enabled edges since the last idle reference point
      if (auto_en && (j - m_tref == TO)) ev[2] = 1'b1;
      gr = 3'b000;
      m_step = 0;
      if (m_pend != 0 && (j - m_last) >= HOLD + 2) begin
        m_step = 1;
        if (m_pend[0])      begin gr = 3'b001; m_src = 2'b01; end
        else if (m_pend[1]) begin gr = 3'b010; m_src = 2'b10; end
        else                begin gr = 3'b100; m_src = 2'b11; end
        m_sel  = in_sel;
        m_cnt  = m_cnt + 8'd1;
        m_last = j;
      end
      if (!auto_en || m_step || ev[2]) m_tref = j;
      m_pend = (m_pend & ~gr) | ev;
    end
    m_valid = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_step", 8'(step), 8'(m_step));
      chk("m_sel", 8'(sel), 8'(m_sel));
      chk("m_src", 8'(src), 8'(m_src));
      chk("m_cnt", step_cnt, m_cnt);
      chk("m_pend", 8'(pending), 8'(m_pend));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", gcyc);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  int         nsteps;
  int         first;
  logic [1:0] srcv;
  logic [4:0] pat;
  logic [2:0] pv;
  logic [1:0] sv;
  logic [1:0] cv;
  logic [7:0] nv;
  int         idx [8];
  logic [1:0] sidx [8];

  task automatic record(input int i);
    if (step) begin
      if (nsteps < 8) begin
        idx[nsteps]  = i;
        sidx[nsteps] = src;
      end
      nsteps++;
    end
  endtask

  initial begin
    rst_n = 0; rotation_event = 1; pb = 1; auto_en = 0; in_sel = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_step", 8'(step), 8'd0);
    chk("rst_sel", 8'(sel), 8'd0);
    chk("rst_src", 8'(src), 8'd0);
    chk("rst_cnt", step_cnt, 8'd0);
    chk("rst_pend", 8'(pending), 8'd0);
    rst_n = 1;

    // high levels at release: nothing happens
    nsteps = 0;
    repeat (50) begin @(negedge clk); if (step) nsteps++; end
    chk("t1_nsteps", 8'(nsteps), 8'd0);
    chk("t1_cnt", step_cnt, 8'd0);
    chk("t1_pend", 8'(pending), 8'd0);

    // rotation edge: step visible after the 4th edge
    rotation_event = 0;
    repeat (6) @(negedge clk);
    rotation_event = 1; in_sel = 2'b10;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      pat[i-1] = step;
      if (i == 3) pv = pending;
      if (i == 4) begin sv = sel; cv = src; nv = step_cnt; end
    end
    chk("t2_pattern", 8'(pat), 8'b01000);
    chk("t2_pend", 8'(pv), 8'b001);
    chk("t2_sel", 8'(sv), 8'b10);
    chk("t2_src", 8'(cv), 8'b01);
    chk("t2_cnt", nv, 8'd1);
    in_sel = 2'b01;
    repeat (5) @(negedge clk);
    chk("t2_sel_hold", 8'(sel), 8'b10);

    // bouncing pushbutton: only the final stable rise counts
    pb = 0;
    repeat (10) @(negedge clk);
    pb = 1; @(negedge clk);
    pb = 0; @(negedge clk);
    pb = 1; @(negedge clk);
    pb = 0; @(negedge clk);
    pb = 1;
    nsteps = 0; first = 0; srcv = 2'b00;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (step) begin
        nsteps++;
        if (first == 0) first = i;
        srcv = src;
      end
    end
    chk("t3_nsteps", 8'(nsteps), 8'd1);
    chk("t3_first", 8'(first), 8'd7);
    chk("t3_src", 8'(srcv), 8'b10);

    // rotation and pushbutton requests land on the same edge
    rotation_event = 0; pb = 0;
    repeat (15) @(negedge clk);
    pb = 1;
    nsteps = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      record(i);
      if (i == 6) pv = pending;
      if (i == 3) rotation_event = 1;
    end
    chk("t4_pend", 8'(pv), 8'b011);
    chk("t4_nsteps", 8'(nsteps), 8'd2);
    chk("t4_idx0", 8'(idx[0]), 8'd7);
    chk("t4_src0", 8'(sidx[0]), 8'b01);
    chk("t4_idx1", 8'(idx[1]), 8'd13);
    chk("t4_src1", 8'(sidx[1]), 8'b10);

    // auto-advance, with a rotation step restarting the idle period
    rotation_event = 0;
    repeat (5) @(negedge clk);
    auto_en = 1;
    nsteps = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      record(i);
      if (i == 70) rotation_event = 1;
    end
    chk("t5_nsteps", 8'(nsteps), 8'd5);
    chk("t5_idx0", 8'(idx[0]), 8'd21);
    chk("t5_idx1", 8'(idx[1]), 8'd42);
    chk("t5_idx2", 8'(idx[2]), 8'd63);
    chk("t5_idx3", 8'(idx[3]), 8'd74);
    chk("t5_idx4", 8'(idx[4]), 8'd95);
    chk("t5_src0", 8'(sidx[0]), 8'b11);
    chk("t5_src3", 8'(sidx[3]), 8'b01);
    chk("t5_src4", 8'(sidx[4]), 8'b11);

    // reset pulse during ISSUE with pb and tmr still pending
    auto_en = 0; rotation_event = 0; pb = 0;
    nsteps = 0;
    for (int i = 1; i <= 62; i++) begin
      @(negedge clk);
      if (i == 10) auto_en = 1;
      if (i == 24) pb = 1;
      if (i == 27) rotation_event = 1;
      if (i == 30) chk("t6_pend_all", 8'(pending), 8'b111);
      if (i == 31) begin
        chk("t6_issue_step", 8'(step), 8'd1);
        chk("t6_issue_src", 8'(src), 8'b01);
        chk("t6_issue_pend", 8'(pending), 8'b110);
        chk("t6_issue_cnt", step_cnt, 8'd10);
        rst_n = 0; auto_en = 0;
      end
      if (i == 32) begin
        chk("t6_rst_step", 8'(step), 8'd0);
        chk("t6_rst_pend", 8'(pending), 8'd0);
        chk("t6_rst_src", 8'(src), 8'd0);
        chk("t6_rst_sel", 8'(sel), 8'd0);
        chk("t6_rst_cnt", step_cnt, 8'd0);
        rst_n = 1;
      end
      if (i > 32 && step) nsteps++;
    end
    chk("t6_quiet", 8'(nsteps), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/step_sequencer.md
# step_sequencer

Step-event controller in front of the 13-state dispatch FSM. It merges three step sources into one registered single-cycle `step` pulse: rotary rotation edges, a debounced pushbutton, and an idle auto-advance timer. Contention between the sources is resolved by fixed priority, and consecutive steps are separated by a hold-off gap. With each pulse it latches the 2-bit dispatch selector, so the FSM's dispatch lookup sees a stable value.

## Interface
- `TIMEOUT`, 100000000: idle cycles before an auto-advance request (≥2).
- `DEBOUNCE`, 1000000: cycles the pushbutton must be stable before a level change is accepted (≥1).
- `HOLDOFF`, 4: cycles after a step during which no new step is granted (≥1).
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `rotation_event` in 1: raw encoder rotation level, asynchronous.
- `pb` in 1: raw pushbutton level, asynchronous, bouncing.
- `auto_en` in 1: enables the auto-advance timer, synchronous.
- `in` in 2: dispatch selector, synchronous.
- `step` out 1: one-cycle advance pulse to the FSM.
- `sel` out 2: value of `in` captured on the cycle that `step` is issued.
- `src` out 2: source of the last step (00 none, 01 rotation, 10 pushbutton, 11 timer).
- `step_cnt` out 8: count of issued steps, wraps 255→0.
- `pending` out 3: sticky request bits {tmr, pb, rot}.

## Operation
- **Reset state** (`rst_n`=0 at an edge):
  - `step`=0, `sel`=00, `src`=00, `step_cnt`=0, `pending`=000.
  - Timer=0, hold-off count=0, state IDLE.
  - Rotation synchronizer and edge-history flops set to 1.
  - Pushbutton synchronizer and debounced level set to 1.
  - Effect: a level already high at reset release produces no request.
- **Rotation path:** 2-flop synchronizer, then a history flop. A 0→1 transition of the synchronized level sets `pending[0]`.
- **Pushbutton path:** 2-flop synchronizer, then a debounce counter.
  - The counter resets whenever the synchronized level equals the debounced level.
  - When it reaches DEBOUNCE-1 while the levels differ, the debounced level flips and the counter clears.
  - A debounced 0→1 sets `pending[1]`.
- **Timer:**
  - Held at 0 while `auto_en`=0.
  - Otherwise increments each cycle. On reaching TIMEOUT-1 it sets `pending[2]` and wraps to 0.
  - Cleared to 0 on any issued step (it measures idle time).
- **Pending bits:** sticky, one deep. Repeat events collapse into the existing bit. If a set and a clear for the same bit occur in the same cycle, the set wins.
- **FSM:**
  - IDLE: if `pending`≠0, go to ISSUE and grant by priority rot > pb > tmr.
  - ISSUE (one cycle):
    - `step`=1, `sel`←`in`, `src`←grant code, `step_cnt`+1.
    - Clear the granted pending bit only.
    - Load the hold-off counter with HOLDOFF.
    - Go to HOLD.
  - HOLD: decrement the counter. Requests are still recorded but not granted. At 0, go to IDLE.
- `sel` and `src` hold their values between steps.

## Timing
- **Rotation latency:** `rotation_event` first sampled high at edge k sets `pending[0]` at k+2. The FSM enters ISSUE and `step`=1 after edge k+3, high for exactly one cycle. This assumes the FSM was in IDLE.
- **Pushbutton latency:** sampled high at edge k, stable → `pending[1]` at k+1+DEBOUNCE → `step` one edge later.
- **Timer latency:** with `auto_en`=1 and no other steps, a timer step issues every TIMEOUT+1 cycles: timer period plus one ISSUE edge.
- **Minimum step spacing:** HOLDOFF+2 cycles, rising edge of `step` to next rising edge.
- **Reset mid-operation:** any cycle, including ISSUE. All outputs return to reset values at that edge. Pending requests are discarded. `step` never extends past the reset edge.
- **Simultaneous requests:** rot and pb set in the same cycle → rot granted first; pb issues after the hold-off.
- **Toggling `auto_en`:** 1→0 clears the timer but keeps an already-set `pending[2]`.

## Test plan
All scenarios use TIMEOUT=20, DEBOUNCE=4, HOLDOFF=4.
- Release reset with `rotation_event`=1 and `pb`=1, no further activity for 50 cycles → `step` stays 0, `pending`=000, `step_cnt`=0.
- Rotation 0→1 with `in`=10, sampled at edge k → `step`=1 only after edge k+3, `sel`=10, `src`=01, `step_cnt`=1.
- `pb` bounces 1-0-1-0 at 1-cycle intervals, then holds 1 → exactly one step, `src`=10. Bounces shorter than 4 cycles create no step.
- Rotation edge and debounced pb rise set in the same cycle → two steps with rising edges 6 cycles apart, `src` 01 then 10.
- `auto_en`=1, idle → steps every 21 cycles, `src`=11. A rotation step mid-period restarts the 21-cycle count from that step.
- `rst_n` pulsed low during ISSUE with `pending`=110 → `step` low at that edge, `pending`=000, `src`=00, and no step for 30 cycles after release.
